// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS control FSM.
//               Holds the ALU operation selects, opcode and funct values,
//               operand-B and PC-source mux codes, and the 4-bit state
//               encoding that is also exported on the debug port.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // ALU operation select
  localparam logic [1:0] ALU_SEL_ADD = 2'd0;
  localparam logic [1:0] ALU_SEL_SUB = 2'd1;
  localparam logic [1:0] ALU_SEL_OR  = 2'd2;
  localparam logic [1:0] ALU_SEL_SLT = 2'd3;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // ALU operand-B mux
  localparam logic [1:0] SRCB_REG  = 2'd0;  // reg B (rt)
  localparam logic [1:0] SRCB_FOUR = 2'd1;  // constant 4
  localparam logic [1:0] SRCB_IMM  = 2'd2;  // extended immediate
  localparam logic [1:0] SRCB_BR   = 2'd3;  // sign-extended imm << 2

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'd0;  // live ALU result
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;  // latched branch target
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;  // jump target

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_alu_funct_dec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_alu_funct_dec
// Description : Purely combinational R-type funct decoder.
//   funct          in  6  IR[5:0]
//   alu_sel        out 2  ALU operation for this funct (ADD when unsupported)
//   is_checked_add out 1  funct is signed ADD, whose overflow may trap
//   legal          out 1  funct is supported
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_alu_funct_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] alu_sel,
  output logic       is_checked_add,
  output logic       legal
);

  always_comb begin
    alu_sel        = ALU_SEL_ADD;
    is_checked_add = 1'b0;
    legal          = 1'b1;
    case (funct)
      FUNCT_ADD: begin
        alu_sel        = ALU_SEL_ADD;
        is_checked_add = 1'b1;
      end
      FUNCT_ADDU: alu_sel = ALU_SEL_ADD;
      FUNCT_SUBU: alu_sel = ALU_SEL_SUB;
      FUNCT_OR:   alu_sel = ALU_SEL_OR;
      FUNCT_SLT:  alu_sel = ALU_SEL_SLT;
      default:    legal   = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle control FSM for the MIPS core. Sequences
//               FETCH/DECODE/EXEC/MEM/WB, drives ALU and datapath mux
//               controls, and handshakes with one shared memory port.
//   clk, rst                 clock; asynchronous active-high reset
//   instr_op, instr_funct    IR[31:26], IR[5:0]
//   alu_zero, alu_overflow   ALU flags
//   mem_ready                memory accepted/completed the current request
//   alu_sel, alu_src_a/b, imm_zext          ALU controls
//   pc_we, pc_src, ir_we, iord              PC / IR / address controls
//   mem_req, mem_we                         memory request
//   reg_we, reg_dst, mem_to_reg             register-file write controls
//   illegal, exc_ovf                        sticky exception flags
//   state_o                                 current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter bit TRAP_ON_OVERFLOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       mem_ready,
  output logic [1:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       exc_ovf,
  output logic [3:0] state_o
);
  import mc_ctrl_pkg::*;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_illegal;
  logic       r_exc_ovf;
  logic       r_ovf;          // overflow of a checked ADD, captured in EXEC_R
  logic       w_set_illegal;
  logic       w_set_exc_ovf;

  logic [1:0] w_dec_sel;
  logic       w_dec_checked;
  logic       w_dec_legal;

  mc_ctrl_alu_funct_dec u_funct_dec (
    .funct          (instr_funct),
    .alu_sel        (w_dec_sel),
    .is_checked_add (w_dec_checked),
    .legal          (w_dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_exc_ovf <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_exc_ovf) r_exc_ovf <= 1'b1;
      if (r_state == S_EXEC_R) r_ovf <= alu_overflow & w_dec_checked;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    w_set_exc_ovf = 1'b0;
    alu_sel       = ALU_SEL_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    imm_zext      = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PCSRC_ALU;
    ir_we         = 1'b0;
    iord          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_we        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed every cycle; it is only committed with the IR.
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we        = 1'b1;
          pc_we        = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is formed speculatively and latched in ALUOut.
        alu_src_b = SRCB_BR;
        case (instr_op)
          OP_RTYPE:         w_next_state = S_EXEC_R;
          OP_ADDIU, OP_ORI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   w_next_state = S_BRANCH;
          OP_J:             w_next_state = S_JUMP;
          default: begin
            w_next_state  = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = w_dec_sel;
        if (w_dec_legal) begin
          w_next_state = S_WB_R;
        end else begin
          w_next_state  = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_WB_R: begin
        reg_we       = 1'b1;
        reg_dst      = 1'b1;
        w_next_state = S_FETCH;
        if (r_ovf && TRAP_ON_OVERFLOW) begin
          reg_we        = 1'b0;
          w_set_exc_ovf = 1'b1;
          w_next_state  = S_HALT;
        end
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (instr_op == OP_ORI) begin
          alu_sel  = ALU_SEL_OR;
          imm_zext = 1'b1;
        end
        w_next_state = S_WB_I;
      end
      S_WB_I: begin
        reg_we       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_next_state = (instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next_state = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_we       = 1'b1;
        mem_to_reg   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_sel      = ALU_SEL_SUB;
        pc_src       = PCSRC_ALUOUT;
        pc_we        = (instr_op == OP_BEQ) ? alu_zero : ~alu_zero;
        w_next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_we        = 1'b1;
        pc_src       = PCSRC_JUMP;
        w_next_state = S_FETCH;
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_HALT;
    endcase

    // Reset squashes every output combinationally so an in-flight memory
    // request is withdrawn in the same cycle reset is raised.
    if (rst) begin
      alu_sel    = ALU_SEL_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      imm_zext   = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PCSRC_ALU;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign illegal = r_illegal & ~rst;
  assign exc_ovf = r_exc_ovf & ~rst;
  assign state_o = rst ? 4'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl. Two instances
//               share stimulus: u_trap (TRAP_ON_OVERFLOW=1) and u_wrap
//               (TRAP_ON_OVERFLOW=0). Each check compares a packed control
//               word {alu_sel, src_a, src_b, imm_zext, pc_we, pc_src, ir_we,
//               iord, mem_req, mem_we, reg_we, reg_dst, mem_to_reg, illegal,
//               exc_ovf, state_o} against a hand-built expected word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_op;
  logic [5:0] instr_funct;
  logic       alu_zero;
  logic       alu_overflow;
  logic       mem_ready;

  logic [1:0] alu_sel_t, alu_src_b_t, pc_src_t, alu_sel_w, alu_src_b_w, pc_src_w;
  logic       alu_src_a_t, imm_zext_t, pc_we_t, ir_we_t, iord_t, mem_req_t, mem_we_t;
  logic       reg_we_t, reg_dst_t, mem_to_reg_t, illegal_t, exc_ovf_t;
  logic       alu_src_a_w, imm_zext_w, pc_we_w, ir_we_w, iord_w, mem_req_w, mem_we_w;
  logic       reg_we_w, reg_dst_w, mem_to_reg_w, illegal_w, exc_ovf_w;
  logic [3:0] state_t_o, state_w_o;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.TRAP_ON_OVERFLOW(1'b1)) u_trap (
    .clk(clk), .rst(rst), .instr_op(instr_op), .instr_funct(instr_funct),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
    .alu_sel(alu_sel_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
    .imm_zext(imm_zext_t), .pc_we(pc_we_t), .pc_src(pc_src_t), .ir_we(ir_we_t),
    .iord(iord_t), .mem_req(mem_req_t), .mem_we(mem_we_t), .reg_we(reg_we_t),
    .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t), .illegal(illegal_t),
    .exc_ovf(exc_ovf_t), .state_o(state_t_o)
  );

  mc_ctrl #(.TRAP_ON_OVERFLOW(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .instr_op(instr_op), .instr_funct(instr_funct),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
    .alu_sel(alu_sel_w), .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w),
    .imm_zext(imm_zext_w), .pc_we(pc_we_w), .pc_src(pc_src_w), .ir_we(ir_we_w),
    .iord(iord_w), .mem_req(mem_req_w), .mem_we(mem_we_w), .reg_we(reg_we_w),
    .reg_dst(reg_dst_w), .mem_to_reg(mem_to_reg_w), .illegal(illegal_w),
    .exc_ovf(exc_ovf_w), .state_o(state_w_o)
  );

  logic [21:0] obs_t, obs_w;
  assign obs_t = {alu_sel_t, alu_src_a_t, alu_src_b_t, imm_zext_t, pc_we_t, pc_src_t,
                  ir_we_t, iord_t, mem_req_t, mem_we_t, reg_we_t, reg_dst_t,
                  mem_to_reg_t, illegal_t, exc_ovf_t, state_t_o};
  assign obs_w = {alu_sel_w, alu_src_a_w, alu_src_b_w, imm_zext_w, pc_we_w, pc_src_w,
                  ir_we_w, iord_w, mem_req_w, mem_we_w, reg_we_w, reg_dst_w,
                  mem_to_reg_w, illegal_w, exc_ovf_w, state_w_o};

  function automatic logic [21:0] mk(
    input logic [3:0] st, input logic [1:0] sel, input logic sa, input logic [1:0] sb,
    input logic zx, input logic pcw, input logic [1:0] pcs, input logic irw,
    input logic io, input logic rq, input logic mw, input logic rw, input logic rd,
    input logic m2r, input logic ill, input logic ex);
    return {sel, sa, sb, zx, pcw, pcs, irw, io, rq, mw, rw, rd, m2r, ill, ex, st};
  endfunction

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [21:0] w_zero, w_frdy, w_fwait, w_dec, w_wbr, w_halt_ill;

  task automatic do_reset(input string tag);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk({tag, "_during"}, obs_t, w_zero);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_fetch"}, obs_t, w_frdy);
  endtask

  initial begin
    //            st  sel sa sb zx pw ps iw io rq mw rw rd mr il ex
    w_zero     = '0;
    w_frdy     = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    w_fwait    = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    w_dec      = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    w_wbr      = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    w_halt_ill = mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    rst = 1'b1; instr_op = 6'h00; instr_funct = 6'h21;
    alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b1;

    // Reset: everything low, including FETCH's mem_req
    #2;
    chk("rst_trap", obs_t, w_zero);
    chk("rst_wrap", obs_w, w_zero);
    tick();
    chk("rst_held", obs_t, w_zero);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fetch_first", obs_t, w_frdy);

    // ADDU with overflow flag high: unchecked, so normal writeback
    tick(); chk("addu_decode", obs_t, w_dec);
    tick(); alu_overflow = 1'b1; #1;
    chk("addu_exec", obs_t, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); alu_overflow = 1'b0; #1;
    chk("addu_wb", obs_t, w_wbr);
    tick(); chk("addu_next_fetch", obs_t, w_frdy);

    // R-type funct mapping swept within EXEC_R
    instr_funct = 6'h25;
    tick(); tick();
    chk("or_exec", obs_t, mk(2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    instr_funct = 6'h23; #1;
    chk("subu_exec", obs_t, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    instr_funct = 6'h2A; #1;
    chk("slt_exec", obs_t, mk(2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("slt_wb", obs_t, w_wbr);
    tick();

    // LW with two wait cycles in MEM_RD: 7 cycles
    instr_op = 6'h23;
    tick();
    tick(); chk("lw_addr", obs_t, mk(6, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    tick(); chk("lw_rd_wait1", obs_t, mk(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tick(); chk("lw_rd_wait2", obs_t, mk(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'b1; #1;
    chk("lw_rd_done", obs_t, mk(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tick(); chk("lw_wb", obs_t, mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

    // SW, with one fetch wait cycle first
    tick(); instr_op = 6'h2B; mem_ready = 1'b0; #1;
    chk("fetch_wait", obs_t, w_fwait);
    tick(); chk("fetch_wait_hold", obs_t, w_fwait);
    mem_ready = 1'b1; #1;
    chk("fetch_ready", obs_t, w_frdy);
    tick(); tick();
    tick(); chk("sw_wr", obs_t, mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    tick(); chk("sw_next_fetch", obs_t, w_frdy);

    // ORI then ADDIU
    instr_op = 6'h0D;
    tick(); tick();
    chk("ori_exec", obs_t, mk(4, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("ori_wb", obs_t, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tick(); instr_op = 6'h09;
    tick(); tick();
    chk("addiu_exec", obs_t, mk(4, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); tick();

    // BEQ taken, BNE not taken / taken, J
    instr_op = 6'h04; alu_zero = 1'b1;
    tick(); tick();
    chk("beq_taken", obs_t, mk(10, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("beq_next_fetch", obs_t, w_frdy);
    instr_op = 6'h05;
    tick(); tick();
    chk("bne_zero", obs_t, mk(10, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    alu_zero = 1'b0; #1;
    chk("bne_nonzero", obs_t, mk(10, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); instr_op = 6'h02;
    tick(); tick();
    chk("j_jump", obs_t, mk(11, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("j_next_fetch", obs_t, w_frdy);

    // Checked ADD overflow: trap vs wrap instances diverge
    instr_op = 6'h00; instr_funct = 6'h20;
    tick(); tick(); alu_overflow = 1'b1; #1;
    chk("add_exec", obs_t, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); alu_overflow = 1'b0; #1;
    chk("add_wb_trap", obs_t, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("add_wb_wrap", obs_w, w_wbr);
    tick();
    chk("ovf_halt_trap", obs_t, mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("ovf_continue_wrap", obs_w, w_frdy);
    tick();
    chk("ovf_halt_hold", obs_t, mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    do_reset("rst_clr_exc");

    // Illegal opcode
    instr_op = 6'h3F;
    tick(); chk("badop_decode", obs_t, w_dec);
    tick(); chk("badop_halt", obs_t, w_halt_ill);
    tick(); chk("badop_hold", obs_t, w_halt_ill);
    do_reset("rst_clr_ill");

    // Illegal funct
    instr_op = 6'h00; instr_funct = 6'h08;
    tick(); tick();
    chk("badfn_exec", obs_t, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("badfn_halt", obs_t, w_halt_ill);
    do_reset("rst_clr_ill2");

    // Reset while a store is pending
    instr_op = 6'h2B;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("sw_pending", obs_t, mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    do_reset("rst_mid_write");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS core. It produces the ALU's operation select and operand-mux controls, and it consumes the ALU's zero and overflow flags. It also sequences the PC, IR, register-file and memory enables over FETCH/DECODE/EXEC/MEM/WB, and handshakes with a single shared instruction/data memory port via req/ready.

Parameters:
TRAP_ON_OVERFLOW, 1, 1: signed add overflow suppresses writeback and halts with exc_ovf; 0: wrapped result is written.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
instr_op  in  6  IR[31:26]
instr_funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
mem_ready  in  1  memory accepted/completed current request this cycle
alu_sel  out  2  ALU op, `ALU_SEL_ADD/SUB/OR/SLT
alu_src_a  out  1  0=PC, 1=reg A (rs)
alu_src_b  out  2  0=reg B (rt), 1=const 4, 2=extended imm, 3=sign-ext imm<<2
imm_zext  out  1  1=zero-extend imm (ORI), 0=sign-extend
pc_we  out  1  PC write enable
pc_src  out  2  0=ALU result, 1=ALUOut reg (branch target), 2=jump target
ir_we  out  1  IR write enable
iord  out  1  0=memory address is PC, 1=ALUOut
mem_req  out  1  memory request
mem_we  out  1  memory write (qualifies mem_req)
reg_we  out  1  register-file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal  out  1  sticky: unsupported opcode/funct decoded
exc_ovf  out  1  sticky: overflow trap taken
state_o  out  4  current state, debug

Behaviour:
- Only clk is used; reset is asynchronous and active-high. rst high: state=FETCH, illegal=0, exc_ovf=0, ovf_q=0, and all outputs forced to 0 while rst is high. The first FETCH outputs appear in the cycle after rst deasserts. rst mid-operation drops mem_req in the same cycle; no write completes.
- Outputs are Moore-decoded from state. Exceptions: alu_sel in EXEC_R depends on funct; pc_we in BRANCH depends on alu_zero.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, src_a=PC, src_b=1, ADD. Hold until mem_ready. In the mem_ready cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: src_a=PC, src_b=3, ADD (datapath latches the branch target in ALUOut). Next state by op:
  - 0x00 → EXEC_R
  - 0x09 ADDIU, 0x0D ORI → EXEC_I
  - 0x23 LW, 0x2B SW → MEM_ADDR
  - 0x04 BEQ, 0x05 BNE → BRANCH
  - 0x02 J → JUMP
  - otherwise → HALT, illegal=1
- EXEC_R: src_a=1, src_b=0. Funct mapping:
  - 0x20 ADD → ADD, checked
  - 0x21 ADDU → ADD
  - 0x23 SUBU → SUB
  - 0x25 OR → OR
  - 0x2A SLT → SLT
  - other funct → HALT, illegal=1
- EXEC_R overflow capture: ovf_q <= alu_overflow & (funct==0x20).
- WB_R: reg_we=1, reg_dst=1. If ovf_q and TRAP_ON_OVERFLOW: reg_we=0, exc_ovf=1, go to HALT. Otherwise go to FETCH.
- EXEC_I: src_a=1, src_b=2, ADD for ADDIU; OR with imm_zext=1 for ORI. Then WB_I.
- WB_I: reg_we=1, reg_dst=0, then FETCH.
- MEM_ADDR: src_a=1, src_b=2, ADD. Then MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, iord=1; hold until mem_ready, then WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then FETCH.
- BRANCH: src_a=1, src_b=0, SUB. pc_we = (BEQ ? alu_zero : ~alu_zero), pc_src=1. Then FETCH.
- JUMP: pc_we=1, pc_src=2, then FETCH.
- HALT: absorbing; all enables 0; only rst exits.
- mem_req stays asserted, with stable iord/mem_we, until mem_ready. mem_ready outside request states is ignored.
- Zero-wait latency (mem_ready constant 1):
  - R/ADDIU/ORI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/BNE/J: 3 cycles
  - Each memory wait cycle adds 1.

Decomposition:
- defines.v holds: `ALU_SEL_*`, opcode and funct constants, state encodings (4-bit), alu_src_b/pc_src codes.
- Sub-module alu_funct_dec: funct → {alu_sel, is_checked_add, legal}; purely combinational.

Test Plan:
- ADDU (op 0x00, funct 0x21), mem_ready=1 → 4-cycle sequence FETCH/DECODE/EXEC_R/WB_R; alu_sel=ADD in EXEC_R; reg_we=1, reg_dst=1 in cycle 4.
- LW with mem_ready low for 2 cycles in MEM_RD → mem_req/iord held for 3 cycles; WB_MEM has mem_to_reg=1; 7 cycles total.
- BEQ with alu_zero=1 → pc_we=1, pc_src=1 in BRANCH; BNE with alu_zero=1 → pc_we=0; both return to FETCH.
- ADD (funct 0x20) with alu_overflow=1 in EXEC_R, TRAP_ON_OVERFLOW=1 → reg_we=0, exc_ovf=1, state_o=HALT and held; with parameter 0 → reg_we=1, continues.
- op 0x3F → illegal=1 after DECODE, HALT, no pc_we; R funct 0x08 → same.
- rst asserted during MEM_WR with mem_req=1 → mem_req and mem_we=0 immediately; after release, FETCH with illegal and exc_ovf cleared.
